// File: rtl/dmme_pkg.sv
// Shared definitions for the dmme systolic array: PE modes, data widths and
// the partial-sum drain state encoding.
package dmme_pkg;

   localparam int PSUM_W    = 16;
   localparam int ROWS_DEF  = 4;
   localparam int ACC_W_DEF = 32;

   typedef enum logic [1:0] {
      PE_MODE_IDLE  = 2'd0,
      PE_MODE_LOADW = 2'd1,
      PE_MODE_MAC   = 2'd2,
      PE_MODE_SHIFT = 2'd3
   } pe_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_OUTPUT  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/psum_drain_if.sv
// Partial-sum drain bus: psum input stream from the bottom PE plus the
// valid/ready result stream and status flags.
interface psum_drain_if #(
   parameter int ROWS  = 4,
   parameter int ACC_W = 32
);
   logic                     psum_vld;
   logic [15:0]              psum_in;
   logic                     first_tile;
   logic                     last_tile;
   logic                     out_valid;
   logic                     out_ready;
   logic [ACC_W-1:0]         out_data;
   logic [$clog2(ROWS)-1:0]  out_idx;
   logic                     busy;
   logic                     err_ovf;

   modport master (
      output psum_vld, psum_in, first_tile, last_tile, out_ready,
      input  out_valid, out_data, out_idx, busy, err_ovf
   );

   modport slave (
      input  psum_vld, psum_in, first_tile, last_tile, out_ready,
      output out_valid, out_data, out_idx, busy, err_ovf
   );
endinterface

// File: rtl/psum_drain_acc_buf.sv
// Accumulator register file: one write port that either overwrites with the
// sign-extended psum or adds it to the stored value, one combinational read.
module psum_acc_buf
   import dmme_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                     clock,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(ROWS)-1:0]  wr_addr,
   input  logic [PSUM_W-1:0]        wr_psum,
   input  logic                     wr_first,
   input  logic [$clog2(ROWS)-1:0]  rd_addr,
   output logic [ACC_W-1:0]         rd_data
);

    logic [ACC_W-1:0] mem [ROWS];
    logic [ACC_W-1:0] ext;

    assign ext     = ACC_W'($signed(wr_psum));
    assign rd_data = mem[rd_addr];

    // Addition wraps modulo 2^ACC_W; no saturation.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_first ? ext : (mem[wr_addr] + ext);
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Collects ROWS partial sums per drain into the accumulator buffer and, on a
// last-tile drain, streams the accumulated results out over valid/ready.
//
//   state      | meaning
//   ST_IDLE    | waiting for the first psum of a drain
//   ST_COLLECT | writing entries 1..ROWS-1
//   ST_OUTPUT  | streaming acc[rd_idx]; incoming psums are dropped
module psum_drain
   import dmme_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic          clock,
   input  logic          rst_n,
   psum_drain_if.slave   bus
);

    localparam int                IDX_W    = $clog2(ROWS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);

    drain_state_e      state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              wr_en, wr_first;
    logic [IDX_W-1:0]  wr_addr;
    logic [ACC_W-1:0]  acc_rd;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            first_q <= first_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        first_d  = first_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_addr  = cnt_q;
        wr_first = first_q;
        case (state_q)
            ST_IDLE: begin
                // Entry 0 uses the live first_tile since the latch lands this edge.
                if (bus.psum_vld) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_first = bus.first_tile;
                    first_d  = bus.first_tile;
                    last_d   = bus.last_tile;
                    cnt_d    = IDX_W'(1);
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.psum_vld) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        rd_d    = '0;
                        state_d = last_q ? ST_OUTPUT : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_OUTPUT: begin
                if (bus.psum_vld) ovf_d = 1'b1;
                if (bus.out_ready) begin
                    if (rd_q == LAST_IDX) begin
                        rd_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        rd_d = rd_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    psum_acc_buf #(
        .ROWS  (ROWS),
        .ACC_W (ACC_W)
    ) u_buf (
        .clock    (clock),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_psum  (bus.psum_in),
        .wr_first (wr_first),
        .rd_addr  (rd_q),
        .rd_data  (acc_rd)
    );

    assign bus.out_valid = (state_q == ST_OUTPUT);
    assign bus.out_data  = bus.out_valid ? acc_rd : '0;
    assign bus.out_idx   = bus.out_valid ? rd_q : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.err_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: directed drains plus randomized tiles
// checked against an array model of the accumulators.
module tb_psum_drain;

    localparam int ROWS  = 4;
    localparam int ACC_W = 32;
    localparam longint MASK = 64'hFFFF_FFFF;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    psum_drain_if #(.ROWS(ROWS), .ACC_W(ACC_W)) bus ();

    psum_drain #(.ROWS(ROWS), .ACC_W(ACC_W)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    longint      model_acc [ROWS];
    logic [15:0] drv_p [ROWS];
    logic [31:0] obs_d [ROWS];
    logic [1:0]  obs_i [ROWS];
    bit          rx_to;

    function automatic longint sext16(input logic [15:0] v);
        return longint'($signed(v)) & MASK;
    endfunction

    task automatic model_drain(input bit f);
        for (int i = 0; i < ROWS; i++)
            model_acc[i] = f ? sext16(drv_p[i]) : ((model_acc[i] + sext16(drv_p[i])) & MASK);
    endtask

    task automatic idle_inputs();
        bus.psum_vld   = 1'b0;
        bus.psum_in    = 16'(($urandom));
        bus.first_tile = 1'($urandom);
        bus.last_tile  = 1'($urandom);
    endtask

    // Flags on non-leading psums and gap cycles are randomized; they must be ignored.
    task automatic send_drain(input bit f, input bit l, input int gap);
        for (int i = 0; i < ROWS; i++) begin
            bus.psum_vld   = 1'b1;
            bus.psum_in    = drv_p[i];
            bus.first_tile = (i == 0) ? f : 1'($urandom);
            bus.last_tile  = (i == 0) ? l : 1'($urandom);
            @(negedge clock);
            if (i < ROWS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    idle_inputs();
                    @(negedge clock);
                end
            end
        end
        idle_inputs();
        model_drain(f);
    endtask

    task automatic receive(input bit rnd);
        int  n = 0;
        int  cyc = 0;
        bit  r;
        rx_to = 1'b0;
        while (n < ROWS && cyc < 300) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = r;
            if (bus.out_valid && r) begin
                obs_d[n] = bus.out_data;
                obs_i[n] = bus.out_idx;
                n++;
            end
            @(negedge clock);
            cyc++;
        end
        bus.out_ready = 1'b0;
        rx_to = (n < ROWS);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.err_ovf, bus.out_data, bus.out_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b ovf=%b data=%h idx=%0d required all zero",
                     bus.out_valid, bus.busy, bus.err_ovf, bus.out_data, bus.out_idx);
        end
        for (int i = 0; i < ROWS; i++) model_acc[i] = 0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        do_reset();
        // Accumulating onto a freshly reset buffer must yield the bare psums.
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(($urandom));
        send_drain(1'b0, 1'b1, 0);
        receive(1'b0);
        checks++;
        if (rx_to) begin errors++; $display("FAIL reset_rx_timeout: got timeout required 4 results"); end
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(model_acc[i])) begin
                errors++;
                $display("FAIL reset_acc_zero[%0d]: got %h required %h", i, obs_d[i], 32'(model_acc[i]));
            end
        end
    endtask

    task automatic test_single_tile();
        drv_p[0] = 16'd5; drv_p[1] = 16'hFFFD; drv_p[2] = 16'd100; drv_p[3] = 16'h8000;
        send_drain(1'b1, 1'b1, 0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got out_valid=%b required 1", bus.out_valid);
        end
        receive(1'b0);
        checks++;
        if (rx_to) begin errors++; $display("FAIL single_rx_timeout: got timeout required 4 results"); end
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(model_acc[i]) || obs_i[i] !== 2'(i)) begin
                errors++;
                $display("FAIL single_out[%0d]: got %h idx %0d required %h idx %0d",
                         i, obs_d[i], obs_i[i], 32'(model_acc[i]), i);
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_two_tile();
        bit quiet = 1'b1;
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(i + 1);
        send_drain(1'b1, 1'b0, 0);
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
            @(negedge clock);
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL tile_a_quiet: got valid/busy high required low"); end
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(10 * (i + 1));
        send_drain(1'b0, 1'b1, 0);
        receive(1'b1);
        checks++;
        if (rx_to) begin errors++; $display("FAIL two_tile_rx_timeout: got timeout required 4 results"); end
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(model_acc[i]) || obs_i[i] !== 2'(i)) begin
                errors++;
                $display("FAIL two_tile_out[%0d]: got %h idx %0d required %h idx %0d",
                         i, obs_d[i], obs_i[i], 32'(model_acc[i]), i);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0, cyc = 0, stalls = 0;
        bit held_ok = 1'b1, order_ok = 1'b1;
        drv_p[0] = 16'd5; drv_p[1] = 16'hFFFD; drv_p[2] = 16'd100; drv_p[3] = 16'h8000;
        send_drain(1'b1, 1'b1, 0);
        while (n < ROWS && cyc < 100) begin
            if (bus.out_valid && bus.out_idx == 2'd1 && stalls < 3) begin
                bus.out_ready = 1'b0;
                if (bus.out_data !== 32'hFFFF_FFFD) held_ok = 1'b0;
                stalls++;
            end else begin
                bus.out_ready = 1'b1;
                if (bus.out_valid) begin
                    if (bus.out_data !== 32'(model_acc[n]) || bus.out_idx !== 2'(n)) order_ok = 1'b0;
                    n++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (!held_ok || stalls != 3) begin
            errors++;
            $display("FAIL bp_hold: got held_ok=%b stalls=%0d required 1 3", held_ok, stalls);
        end
        checks++;
        if (!order_ok || n != ROWS) begin
            errors++;
            $display("FAIL bp_order: got order_ok=%b count=%0d required 1 %0d", order_ok, n, ROWS);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(($urandom));
        send_drain(1'b1, 1'b1, 0);
        bus.psum_vld = 1'b1; bus.psum_in = 16'd7; bus.first_tile = 1'b1; bus.last_tile = 1'b1;
        @(negedge clock);
        idle_inputs();
        checks++;
        if (bus.err_ovf !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0 ||
            bus.out_data !== 32'(model_acc[0])) begin
            errors++;
            $display("FAIL ovf_flag: got ovf=%b valid=%b idx=%0d data=%h required 1 1 0 %h",
                     bus.err_ovf, bus.out_valid, bus.out_idx, bus.out_data, 32'(model_acc[0]));
        end
        receive(1'b0);
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(model_acc[i])) begin
                errors++;
                $display("FAIL ovf_unchanged[%0d]: got %h required %h", i, obs_d[i], 32'(model_acc[i]));
            end
        end
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(($urandom));
        send_drain(1'b0, 1'b0, 1);
        repeat (3) @(negedge clock);
        checks++;
        if (bus.err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b required 1", bus.err_ovf);
        end
        do_reset();
        checks++;
        if (bus.err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reset_clear: got %b required 0", bus.err_ovf);
        end
    endtask

    task automatic test_final_coincide();
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(($urandom));
        send_drain(1'b1, 1'b1, 0);
        bus.out_ready = 1'b1;
        repeat (ROWS - 1) @(negedge clock);
        bus.psum_vld = 1'b1; bus.psum_in = 16'h1234; bus.first_tile = 1'b1; bus.last_tile = 1'b1;
        @(negedge clock);
        idle_inputs();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL coincide_drop: got busy=%b valid=%b ovf=%b required 0 0 1",
                     bus.busy, bus.out_valid, bus.err_ovf);
        end
        for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(($urandom));
        send_drain(1'b0, 1'b1, 0);
        receive(1'b0);
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(model_acc[i])) begin
                errors++;
                $display("FAIL coincide_acc[%0d]: got %h required %h", i, obs_d[i], 32'(model_acc[i]));
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            bus.psum_vld = 1'b1; bus.psum_in = 16'(($urandom)); bus.first_tile = 1'b0; bus.last_tile = 1'b1;
            @(negedge clock);
        end
        idle_inputs();
        do_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got busy=%b valid=%b required 0 0", bus.busy, bus.out_valid);
        end
        drv_p[0] = 16'd9; drv_p[1] = 16'd8; drv_p[2] = 16'd7; drv_p[3] = 16'd6;
        send_drain(1'b1, 1'b1, 0);
        receive(1'b0);
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(9 - i) || obs_i[i] !== 2'(i)) begin
                errors++;
                $display("FAIL mid_reset_out[%0d]: got %h idx %0d required %h idx %0d",
                         i, obs_d[i], obs_i[i], 32'(9 - i), i);
            end
        end
    endtask

    task automatic test_gaps();
        drv_p[0] = 16'd5; drv_p[1] = 16'hFFFD; drv_p[2] = 16'd100; drv_p[3] = 16'h8000;
        send_drain(1'b1, 1'b1, 2);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gaps_latency: got out_valid=%b required 1", bus.out_valid);
        end
        receive(1'b0);
        for (int i = 0; i < ROWS; i++) begin
            checks++;
            if (obs_d[i] !== 32'(model_acc[i]) || obs_i[i] !== 2'(i)) begin
                errors++;
                $display("FAIL gaps_out[%0d]: got %h idx %0d required %h idx %0d",
                         i, obs_d[i], obs_i[i], 32'(model_acc[i]), i);
            end
        end
    endtask

    task automatic test_random();
        bit f, l;
        for (int it = 0; it < 8; it++) begin
            f = (it == 0) ? 1'b1 : 1'($urandom);
            l = 1'($urandom);
            for (int i = 0; i < ROWS; i++) drv_p[i] = 16'(($urandom));
            send_drain(f, l, int'($urandom_range(0, 2)));
            checks++;
            if (bus.out_valid !== l) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b required %b", it, bus.out_valid, l);
            end
            if (l) begin
                receive(1'b1);
                checks++;
                if (rx_to) begin errors++; $display("FAIL rand_rx_timeout[%0d]: got timeout required 4 results", it); end
                for (int i = 0; i < ROWS; i++) begin
                    checks++;
                    if (obs_d[i] !== 32'(model_acc[i]) || obs_i[i] !== 2'(i)) begin
                        errors++;
                        $display("FAIL rand_out[%0d][%0d]: got %h idx %0d required %h idx %0d",
                                 it, i, obs_d[i], obs_i[i], 32'(model_acc[i]), i);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_two_tile();
        test_backpressure();
        test_overflow();
        test_final_coincide();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning the number of PEs in the column and the number of partial sums per drain (power of two, at least 2).
REQ-002 SHALL have parameter ACC_W, default 32, meaning the accumulator and output width in bits.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port psum_vld  input  1  high when psum_in holds a valid shifted-out partial sum from the bottom PE.
REQ-006 SHALL have port psum_in  input  16  signed partial sum (bottom PE cOut).
REQ-007 SHALL have port first_tile  input  1  high when this drain starts a new accumulation; the block overwrites instead of adding.
REQ-008 SHALL have port last_tile  input  1  high when this drain completes the accumulation; results are streamed out afterwards.
REQ-009 SHALL have port out_valid  output  1  high when out_data holds a result.
REQ-010 SHALL have port out_ready  input  1  high when the consumer accepts a result.
REQ-011 SHALL have port out_data  output  ACC_W  signed accumulated result.
REQ-012 SHALL have port out_idx  output  clog2(ROWS)  row index of out_data.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port err_ovf  output  1  sticky flag: a psum arrived while the block was streaming out and was dropped.

Function
REQ-015 SHALL implement three states: IDLE, COLLECT and OUTPUT.
REQ-016 SHALL, in IDLE on psum_vld, capture psum_in into entry 0, latch first_tile and last_tile, set the write count to 1, and enter COLLECT.
REQ-017 SHALL sample first_tile and last_tile only on the psum that starts a drain, and ignore them at all other times.
REQ-018 SHALL, in COLLECT on psum_vld, write entry cnt and then increment cnt; cycles with psum_vld low hold all state.
REQ-019 SHALL write an entry as sext(psum_in) when the latched first flag is 1, and otherwise as acc[i] plus sext(psum_in).
REQ-020 SHALL perform accumulation as two's complement modulo 2^ACC_W, wrapping around with no saturation.
REQ-021 SHALL, after writing entry ROWS-1, enter OUTPUT with rd_idx=0 if the latched last flag is 1, and otherwise return to IDLE.
REQ-022 SHALL, in OUTPUT, drive out_valid=1, out_data=acc[rd_idx] and out_idx=rd_idx.
REQ-023 SHALL increment rd_idx on each cycle where out_valid and out_ready are both high.
REQ-024 SHALL return to IDLE after the transfer at rd_idx=ROWS-1.
REQ-025 SHALL assert out_valid on the cycle after the final psum of a last-tile drain is captured (latency 1).
REQ-026 SHALL hold out_data and out_idx stable while out_valid is high and out_ready is low.
REQ-027 SHALL drive out_valid low outside OUTPUT.
REQ-028 SHALL, on psum_vld during OUTPUT, drop the psum, leave the buffer unchanged and set err_ovf.
REQ-029 SHALL, when the final handshake and psum_vld coincide, treat the psum as arriving in OUTPUT: drop it and set err_ovf.

Reset
REQ-030 SHALL, while rst_n is low, immediately set the state to IDLE, cnt=0, rd_idx=0, all acc entries to 0, the latched flags to 0, out_valid=0, out_data=0, out_idx=0, busy=0 and err_ovf=0.
REQ-031 SHALL abandon any drain that is partially collected or streaming when reset is asserted mid-operation; no stale data SHALL appear afterwards.
REQ-032 SHALL clear err_ovf only through reset.

Structure
REQ-033 SHALL place the state enum (IDLE, COLLECT, OUTPUT), PSUM_W=16 and the ACC_W and ROWS defaults in the shared dmme package, alongside the PE mode constants.
REQ-034 SHALL implement the accumulator register file (ROWS x ACC_W, one write port and one read port, add-or-overwrite) as the sub-module psum_acc_buf.
REQ-035 SHALL keep the FSM and counters in psum_drain itself.

Verification
REQ-036 SHALL cover: single tile, first=last=1, psums 5, -3, 100, -32768 -> out_data 5, 0xFFFFFFFD, 100, 0xFFFF8000 with out_idx 0..3.
REQ-037 SHALL cover: tile A (first=1, last=0) 1, 2, 3, 4 followed by tile B (first=0, last=1) 10, 20, 30, 40 -> outputs 11, 22, 33, 44, with out_valid low after tile A.
REQ-038 SHALL cover: case REQ-036 with out_ready held low for 3 cycles at idx 1 -> out_data held at 0xFFFFFFFD, all four outputs delivered in order.
REQ-039 SHALL cover: psum_vld=1 with psum 7 during OUTPUT -> err_ovf=1 until reset, outputs unchanged.
REQ-040 SHALL cover: rst_n pulsed low after 2 psums of a drain, then a fresh single-tile drain 9, 8, 7, 6 -> outputs 9, 8, 7, 6.
REQ-041 SHALL cover: case REQ-036 with psum_vld gaps of 2 idle cycles between psums -> identical outputs.
